pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register for the RV32 datapath: the successor to the plain 32-bit reset flop.
- Adds a valid/ready handshake, a 2-entry skid buffer, a synchronous flush and a configurable reset value.
- Sits between pipeline stages (IF/ID, ID/EX, ...).
- Sustains one transfer per cycle under backpressure, and in_ready is driven purely from a register.

---
 rtl/pipe_stage_reg.sv | 185 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with a 2-entry skid
// buffer, synchronous flush and configurable reset value.  Every output is
// taken straight from a flop, so nothing on the input side (in_valid,
// in_data, out_ready) reaches an output combinationally.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
   parameter int               FLUSH_DATA = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [1:0]       count
);

   // Occupancy state; the encoding is {valid_s, valid_m}.  2'b10 (skid
   // holding while main is empty) is unreachable and recovers to empty.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_e;

   state_e           r_state;
   state_e           w_state_nxt;

   logic [WIDTH-1:0] r_data_m;
   logic [WIDTH-1:0] r_data_s;
   logic [WIDTH-1:0] w_data_m_nxt;
   logic [WIDTH-1:0] w_data_s_nxt;

   logic             r_out_valid;
   logic             r_in_ready;
   logic [1:0]       r_count;
   logic             w_out_valid_nxt;
   logic             w_in_ready_nxt;
   logic [1:0]       w_count_nxt;

   logic             w_acc;
   logic             w_pop;
   logic             w_ld_m_in;
   logic             w_ld_m_skid;
   logic             w_ld_s;

   // Handshake qualifiers use only registered copies of our own outputs.
   assign w_acc = in_valid & r_in_ready;
   assign w_pop = r_out_valid & out_ready;

   // Next occupancy and load enables; flush overrides both acc and pop.
   always_comb begin
      w_state_nxt = r_state;
      w_ld_m_in   = 1'b0;
      w_ld_m_skid = 1'b0;
      w_ld_s      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_acc) begin
                  w_ld_m_in   = 1'b1;
                  w_state_nxt = ST_ONE;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (w_pop && w_acc) begin
                  // back-to-back: replace the leaving payload directly
                  w_ld_m_in   = 1'b1;
                  w_state_nxt = ST_ONE;
               end else if (w_pop) begin
                  w_state_nxt = ST_EMPTY;
               end else if (w_acc) begin
                  // output stalled: park the new payload in the skid
                  w_ld_s      = 1'b1;
                  w_state_nxt = ST_FULL;
               end else begin
                  w_state_nxt = ST_ONE;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so no accept can happen
               if (w_pop) begin
                  w_ld_m_skid = 1'b1;
                  w_state_nxt = ST_ONE;
               end else begin
                  w_state_nxt = ST_FULL;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // Next payload registers: shift from skid, load from input, or hold.
   always_comb begin
      w_data_m_nxt = r_data_m;
      w_data_s_nxt = r_data_s;
      if (flush) begin
         if (FLUSH_DATA != 32'sd0) begin
            w_data_m_nxt = RESET_VAL;
            w_data_s_nxt = RESET_VAL;
         end else begin
            w_data_m_nxt = r_data_m;
            w_data_s_nxt = r_data_s;
         end
      end else begin
         if (w_ld_m_in) begin
            w_data_m_nxt = in_data;
         end else if (w_ld_m_skid) begin
            w_data_m_nxt = r_data_s;
         end else begin
            w_data_m_nxt = r_data_m;
         end
         if (w_ld_s) begin
            w_data_s_nxt = in_data;
         end else begin
            w_data_s_nxt = r_data_s;
         end
      end
   end

   // Decode the next occupancy into the registered status outputs.
   always_comb begin
      w_out_valid_nxt = 1'b0;
      w_in_ready_nxt  = 1'b1;
      w_count_nxt     = 2'd0;
      case (w_state_nxt)
         ST_EMPTY: begin
            w_out_valid_nxt = 1'b0;
            w_in_ready_nxt  = 1'b1;
            w_count_nxt     = 2'd0;
         end
         ST_ONE: begin
            w_out_valid_nxt = 1'b1;
            w_in_ready_nxt  = 1'b1;
            w_count_nxt     = 2'd1;
         end
         ST_FULL: begin
            w_out_valid_nxt = 1'b1;
            w_in_ready_nxt  = 1'b0;
            w_count_nxt     = 2'd2;
         end
         default: begin
            w_out_valid_nxt = 1'b0;
            w_in_ready_nxt  = 1'b1;
            w_count_nxt     = 2'd0;
         end
      endcase
   end

   // State, status and payload flops with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_count     <= 2'd0;
         r_data_m    <= RESET_VAL;
         r_data_s    <= RESET_VAL;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_count     <= w_count_nxt;
         r_data_m    <= w_data_m_nxt;
         r_data_s    <= w_data_s_nxt;
      end
   end

   assign out_valid = r_out_valid;
   assign in_ready  = r_in_ready;
   assign count     = r_count;
   assign out_data  = r_data_m;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: three parameterisations driven with the
// same stimulus (A: 32-bit, RESET_VAL=DEADBEEF, data held on flush;
// B: 64-bit, flush loads RESET_VAL; C: 1-bit, RESET_VAL=1).
module tb_pipe_stage_reg;

   localparam logic [31:0] RV_A = 32'hDEAD_BEEF;
   localparam logic [63:0] RV_B = 64'hFEDC_BA98_7654_3210;
   localparam logic [0:0]  RV_C = 1'b1;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        flush;
   logic [31:0] in_data_a;
   logic [63:0] in_data_b;
   logic [0:0]  in_data_c;

   logic        a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
   logic [1:0]  a_cnt, b_cnt, c_cnt;
   logic [31:0] a_od;
   logic [63:0] b_od;
   logic [0:0]  c_od;

   int n_cmp;
   int n_err;

   assign in_data_b = {~in_data_a, in_data_a};
   assign in_data_c = in_data_a[0];

   pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV_A), .FLUSH_DATA(0)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data_a),
      .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .flush(flush), .count(a_cnt));

   pipe_stage_reg #(.WIDTH(64), .RESET_VAL(RV_B), .FLUSH_DATA(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data_b),
      .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .flush(flush), .count(b_cnt));

   pipe_stage_reg #(.WIDTH(1), .RESET_VAL(RV_C), .FLUSH_DATA(0)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data_c),
      .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od), .flush(flush), .count(c_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind: 0 = payload d, 1 = reset value, 2 = after flush (A/C hold d, B reset value)
   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        fl;
      logic        e_ov;
      logic        e_ir;
      logic [1:0]  e_cnt;
      int          kind;
      logic [31:0] e_d;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_a(input int kind, input logic [31:0] d);
      return (kind == 1) ? {32'h0, RV_A} : {32'h0, d};
   endfunction

   function automatic logic [63:0] exp_b(input int kind, input logic [31:0] d);
      return (kind == 0) ? {~d, d} : RV_B;
   endfunction

   function automatic logic [63:0] exp_c(input int kind, input logic [31:0] d);
      return (kind == 1) ? {63'h0, RV_C} : {63'h0, d[0]};
   endfunction

   task automatic chk_all(input string nm, input logic e_ov, input logic e_ir,
                          input logic [1:0] e_cnt, input int kind, input logic [31:0] e_d);
      chk({nm, "_a_out_valid"}, a_ov, e_ov);
      chk({nm, "_a_in_ready"},  a_ir, e_ir);
      chk({nm, "_a_count"},     a_cnt, e_cnt);
      chk({nm, "_a_out_data"},  a_od, exp_a(kind, e_d));
      chk({nm, "_b_out_valid"}, b_ov, e_ov);
      chk({nm, "_b_in_ready"},  b_ir, e_ir);
      chk({nm, "_b_count"},     b_cnt, e_cnt);
      chk({nm, "_b_out_data"},  b_od, exp_b(kind, e_d));
      chk({nm, "_c_out_valid"}, c_ov, e_ov);
      chk({nm, "_c_count"},     c_cnt, e_cnt);
      chk({nm, "_c_out_data"},  c_od, exp_c(kind, e_d));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] q[$];
      logic [31:0] d;
      logic        ir_s;
      logic        acc;
      logic        pop;
      int          pushed;
      int          cyc;

      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      flush = 1'b0;
      in_data_a = 32'h0;

      //            iv    d           rdy   fl    ov    ir    cnt   kind e_d
      vecs[0]  = '{1'b1, 32'h11,   1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 0, 32'h11};
      vecs[1]  = '{1'b1, 32'h22,   1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 0, 32'h22};
      vecs[2]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 0, 32'h22};
      vecs[3]  = '{1'b1, 32'hA,    1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 0, 32'hA};
      vecs[4]  = '{1'b1, 32'hB,    1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 0, 32'hA};
      vecs[5]  = '{1'b1, 32'hC,    1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 0, 32'hA};
      vecs[6]  = '{1'b1, 32'hC,    1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 0, 32'hA};
      vecs[7]  = '{1'b1, 32'hC,    1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 0, 32'hA};
      vecs[8]  = '{1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 0, 32'hB};
      vecs[9]  = '{1'b1, 32'hC,    1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 0, 32'hC};
      vecs[10] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 0, 32'hC};
      vecs[11] = '{1'b1, 32'h5,    1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 0, 32'h5};
      vecs[12] = '{1'b1, 32'h6,    1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 0, 32'h5};
      vecs[13] = '{1'b1, 32'h7,    1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2, 32'h5};
      vecs[14] = '{1'b1, 32'h8,    1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 0, 32'h8};
      vecs[15] = '{1'b1, 32'h9,    1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2, 32'h8};
      vecs[16] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2, 32'h8};
      vecs[17] = '{1'b1, 32'h33,   1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 0, 32'h33};
      vecs[18] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 0, 32'h33};

      // asynchronous reset between edges, checked before any clock edge
      #2;
      rst = 1'b0;
      #1;
      chk_all("reset_async", 1'b0, 1'b1, 2'd0, 1, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // table-driven directed vectors: basic transfer, skid backpressure, flush
      for (int i = 0; i < 19; i++) begin
         in_valid  = vecs[i].iv;
         in_data_a = vecs[i].d;
         out_ready = vecs[i].ordy;
         flush     = vecs[i].fl;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir,
                 vecs[i].e_cnt, vecs[i].kind, vecs[i].e_d);
      end
      flush = 1'b0;

      // reset mid-operation with two entries held
      in_valid = 1'b1; in_data_a = 32'h44; out_ready = 1'b0;
      @(posedge clk); #1;
      in_data_a = 32'h55;
      @(posedge clk); #1;
      chk_all("midrst_full", 1'b1, 1'b0, 2'd2, 0, 32'h44);
      in_valid = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      chk_all("midrst_async", 1'b0, 1'b1, 2'd0, 1, 32'h0);
      #2;
      rst = 1'b1;
      in_valid = 1'b1; in_data_a = 32'h66; out_ready = 1'b1;
      @(posedge clk); #1;
      chk_all("midrst_first", 1'b1, 1'b1, 2'd1, 0, 32'h66);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk_all("midrst_drain", 1'b0, 1'b1, 2'd0, 0, 32'h66);

      // random streaming against a queue scoreboard
      pushed = 0;
      cyc = 0;
      while ((pushed < 1000 || q.size() != 0) && cyc < 20000) begin
         if (!in_valid && pushed < 1000 && $urandom_range(0, 3) != 0) begin
            in_valid  = 1'b1;
            in_data_a = $urandom;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #4;
         ir_s = a_ir;
         out_ready = ~out_ready;
         #1;
         chk("stream_in_ready_comb", a_ir, ir_s);
         out_ready = ~out_ready;
         acc = in_valid & a_ir;
         pop = a_ov & out_ready;
         if (pop) begin
            if (q.size() == 0) begin
               chk("stream_pop_empty", 1'b1, 1'b0);
            end else begin
               d = q.pop_front();
               chk("stream_a_data", a_od, {32'h0, d});
               chk("stream_b_data", b_od, {~d, d});
               chk("stream_c_data", c_od, {63'h0, d[0]});
            end
         end
         if (acc) begin
            q.push_back(in_data_a);
            pushed++;
         end
         @(posedge clk);
         #1;
         if (acc) in_valid = 1'b0;
         chk("stream_a_count", a_cnt, q.size());
         chk("stream_b_count", b_cnt, q.size());
         chk("stream_c_count", c_cnt, q.size());
         chk("stream_out_valid", a_ov, (q.size() != 0));
         chk("stream_in_ready", a_ir, (q.size() < 2));
         cyc++;
      end
      chk("stream_timeout", (cyc >= 20000), 1'b0);
      chk("stream_pushed", pushed, 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
